// File: rtl/indicator_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : indicator_ctrl_if
// Brief    : Status-to-LED bundle between the charger decode logic and indicator_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface indicator_ctrl_if #(
  parameter int NCH   = 2,
  parameter int PWM_W = 4
);
  logic                 button;
  logic                 usb;
  logic [2*NCH-1:0]     mode;
  logic [PWM_W*NCH-1:0] duty;
  logic [NCH-1:0]       led;
  logic                 active;
  logic                 press;

  modport master (
    output button,
    output usb,
    output mode,
    output duty,
    input  led,
    input  active,
    input  press
  );

  modport slave (
    input  button,
    input  usb,
    input  mode,
    input  duty,
    output led,
    output active,
    output press
  );
endinterface
`default_nettype wire

// File: rtl/indicator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : indicator_ctrl
// Brief    : Multi-channel LED indicator with blink modes, PWM dimming and a
//            wake/sleep display state machine driven by button and USB.
// Revision : 1.0 - initial release
// ============================================================================
module indicator_ctrl #(
  parameter int NCH        = 2,
  parameter int TICK_DIV   = 1000,
  parameter int DEB_TICKS  = 20,
  parameter int HOLD_TICKS = 3000,
  parameter int PWM_W      = 4,
  parameter int BLINK_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  indicator_ctrl_if.slave  bus
);

  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_deb_w  = $clog2(DEB_TICKS + 1);
  localparam int c_hold_w = $clog2(HOLD_TICKS + 1);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEB_TICKS - 1);
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_TICKS);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

  typedef enum logic [0:0] {
    ST_SLEEP = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Timebase
  // --------------------------------------------------------------------------
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;

  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Button synchroniser, debounce and press pulse
  // --------------------------------------------------------------------------
  logic               r_sync1;
  logic               r_btn_s;
  logic               r_btn_d;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic               r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_btn_s   <= 1'b0;
      r_btn_d   <= 1'b0;
      r_deb_cnt <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_btn_s <= r_sync1;
      r_press <= 1'b0;
      if (r_btn_s == r_btn_d) begin
        r_deb_cnt <= '0;
      end else if (w_tick) begin
        if (r_deb_cnt == c_deb_last) begin
          // btn_s differs from btn_d here, so btn_s=1 means a rising edge
          r_btn_d   <= r_btn_s;
          r_deb_cnt <= '0;
          r_press   <= r_btn_s;
        end else begin
          r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display state machine and blink phase
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic                r_usb;
  logic                r_active;
  logic [c_hold_w-1:0] r_hold;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                w_keep;
  logic                w_expire;
  logic                w_show_nxt;

  assign w_keep     = r_press | r_usb;
  assign w_expire   = w_tick & (r_hold == c_hold_one);
  // A press or usb in the expiry cycle keeps the display awake
  assign w_show_nxt = w_keep | ((r_state == ST_SHOW) & ~w_expire);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SLEEP;
      r_usb       <= 1'b0;
      r_active    <= 1'b0;
      r_hold      <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_usb <= bus.usb;
      case (r_state)
        ST_SLEEP: begin
          r_blink_cnt <= '0;
          if (w_keep) begin
            r_state  <= ST_SHOW;
            r_hold   <= c_hold_load;
            r_active <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_tick) begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
          end
          if (w_keep) begin
            r_hold <= c_hold_load;
          end else if (w_tick) begin
            if (r_hold == c_hold_one) begin
              r_state  <= ST_SLEEP;
              r_hold   <= '0;
              r_active <= 1'b0;
            end else begin
              r_hold <= r_hold - c_hold_w'(1);
            end
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // PWM and per-channel output gating
  // --------------------------------------------------------------------------
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [NCH-1:0]   w_led_nxt;
  logic [NCH-1:0]   r_led;
  logic             w_slow_on;
  logic             w_fast_on;

  assign w_slow_on = ~r_blink_cnt[BLINK_W-1];
  assign w_fast_on = ~r_blink_cnt[BLINK_W-3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [PWM_W-1:0] w_duty;
    logic [1:0]       w_mode;
    logic             w_gate;
    logic             w_pwm_on;

    assign w_duty   = bus.duty[PWM_W*gi +: PWM_W];
    assign w_mode   = bus.mode[2*gi +: 2];
    // Full-scale duty must stay lit through the counter's top code
    assign w_pwm_on = (r_pwm_cnt < w_duty) | (&w_duty);

    always_comb begin
      w_gate = 1'b0;
      case (w_mode)
        2'b00:   w_gate = 1'b0;
        2'b01:   w_gate = 1'b1;
        2'b10:   w_gate = w_slow_on;
        2'b11:   w_gate = w_fast_on;
        default: w_gate = 1'b0;
      endcase
    end

    assign w_led_nxt[gi] = w_show_nxt & w_gate & w_pwm_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign bus.led    = r_led;
  assign bus.active = r_active;
  assign bus.press  = r_press;

endmodule
`default_nettype wire

// File: tb/tb_indicator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_indicator_ctrl
// Brief    : Directed self-checking bench for indicator_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_indicator_ctrl;

  localparam int NCH        = 2;
  localparam int TICK_DIV   = 4;
  localparam int DEB_TICKS  = 2;
  localparam int HOLD_TICKS = 10;
  localparam int PWM_W      = 4;
  localparam int BLINK_W    = 6;

  logic        clk = 1'b0;
  logic        rst;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] km1;
  logic        exp_act;
  logic        exp_l0;
  logic        exp_l1;
  int          highs;

  indicator_ctrl_if #(.NCH(NCH), .PWM_W(PWM_W)) bus ();

  indicator_ctrl #(
    .NCH        (NCH),
    .TICK_DIV   (TICK_DIV),
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS),
    .PWM_W      (PWM_W),
    .BLINK_W    (BLINK_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Leaves time just after the last reset edge, where tick_cnt is 0
  task automatic do_reset();
    rst        = 1'b1;
    bus.button = 1'b0;
    bus.usb    = 1'b0;
    bus.mode   = '0;
    bus.duty   = '0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with button and usb asserted
    rst        = 1'b1;
    bus.button = 1'b1;
    bus.usb    = 1'b1;
    bus.mode   = '0;
    bus.duty   = '0;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("rst_led",    k, 32'(bus.led),    32'h0);
      check("rst_active", k, 32'(bus.active), 32'h0);
      check("rst_press",  k, 32'(bus.press),  32'h0);
    end
    rst = 1'b0;
    cyc(1);
    check("rst_release_act0", 1, 32'(bus.active), 32'h0);
    cyc(1);
    check("rst_release_act1", 2, 32'(bus.active), 32'h1);

    // Five-cycle glitch spans only one tick: no press, no wake
    do_reset();
    bus.button = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (k == 5) bus.button = 1'b0;
      check("glitch_press",  k, 32'(bus.press),  32'h0);
      check("glitch_active", k, 32'(bus.active), 32'h0);
    end

    // Held press: one pulse at cycle 8, awake 9..47, sleeps on the 10th tick
    do_reset();
    bus.button = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc(1);
      if (k == 16) bus.button = 1'b0;
      check("press_pulse", k, 32'(bus.press),  32'(k == 8));
      check("hold_active", k, 32'(bus.active), 32'(k >= 9 && k <= 47));
    end

    // Second press when hold reaches 2 extends the display by 10 ticks
    do_reset();
    bus.button = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      cyc(1);
      if (k == 12) bus.button = 1'b0;
      if (k == 32) bus.button = 1'b1;
      check("extend_press",  k, 32'(bus.press),  32'(k == 8 || k == 40));
      check("extend_active", k, 32'(bus.active), 32'(k >= 9 && k <= 79));
    end

    // usb keep-alive with ch0 on, ch1 slow blink then fast blink
    do_reset();
    bus.usb  = 1'b1;
    bus.mode = 4'b1001;
    bus.duty = 8'hFF;
    for (int k = 1; k <= 250; k++) begin
      cyc(1);
      if (k == 160) bus.mode = 4'b1101;
      if (k == 200) bus.usb  = 1'b0;
      km1     = 32'(k - 1);
      exp_act = (k >= 2 && k <= 239);
      exp_l0  = exp_act;
      exp_l1  = exp_act & ((k <= 160) ? ~km1[7] : ~km1[5]);
      check("usb_active", k, 32'(bus.active), 32'(exp_act));
      check("mode_led",   k, 32'(bus.led),    32'({exp_l1, exp_l0}));
    end

    // PWM: duty 4 then 0 then full scale on ch0
    do_reset();
    bus.usb  = 1'b1;
    bus.mode = 4'b0001;
    bus.duty = 8'h04;
    highs    = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc(1);
      if (k == 40) bus.duty = 8'h00;
      if (k == 60) bus.duty = 8'h0F;
      km1 = 32'(k - 1);
      if (k < 2)        exp_l0 = 1'b0;
      else if (k <= 40) exp_l0 = (km1[3:0] < 4'd4);
      else if (k <= 60) exp_l0 = 1'b0;
      else              exp_l0 = 1'b1;
      if (k >= 17 && k <= 32 && bus.led[0] === 1'b1) highs++;
      check("pwm_led", k, 32'(bus.led), 32'({1'b0, exp_l0}));
    end
    check("pwm_highs_per_16", 32, 32'(highs), 32'd4);

    // Reset mid-operation clears outputs on the next edge
    rst = 1'b1;
    cyc(1);
    check("midrst_led",    0, 32'(bus.led),    32'h0);
    check("midrst_active", 0, 32'(bus.active), 32'h0);
    rst = 1'b0;
    cyc(1);
    check("midrst_after_active", 1, 32'(bus.active), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
